// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and fetch FSM that reads instruction memory and
// presents each instruction with its PC downstream over valid/ready.
module fetch_pc_unit #(
    parameter int          MEM_LATENCY = 1,
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter logic [11:0] PC_STEP     = 12'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [11:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [11:0] pc,
    input  logic        isBranch,
    input  logic [25:0] pcLabel,
    output logic        misalign,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} fetchState;
    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);
    fetchState state, nextState;
    logic [2:0] waitCnt;
    logic accept;
    logic unusedLabel;
    assign unusedLabel = ^pcLabel[25:12];
    assign accept = state == HOLD && instr_ready;
    assign imem_addr = pc;
    assign imem_en = state == ISSUE;
    assign instr_valid = state == HOLD;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nextState;
    always_comb begin
        nextState = state;
        case (state)
            IDLE:  nextState = start ? ISSUE : IDLE;
            ISSUE: nextState = WAIT;
            WAIT:  nextState = waitCnt == 3'd0 ? HOLD : WAIT;
            HOLD:  nextState = instr_ready ? ISSUE : HOLD;
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            instr <= '0;
            waitCnt <= '0;
            misalign <= 1'b0;
            retired <= '0;
        end else begin
            if (state == IDLE && start) pc <= RESET_PC;
            if (state == ISSUE) waitCnt <= LAT_M1;
            else if (state == WAIT && waitCnt != 3'd0) waitCnt <= waitCnt - 3'd1;
            if (state == WAIT && waitCnt == 3'd0) instr <= imem_data;
            // branch targets are forced word-aligned; misalign records that it happened
            if (accept) begin
                pc <= isBranch ? {pcLabel[11:2], 2'b00} : pc + PC_STEP;
                misalign <= misalign | (isBranch && pcLabel[1:0] != 2'b00);
                if (retired != '1) retired <= retired + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vector bench for fetch_pc_unit with latency-1 and
// latency-3 instances backed by small synchronous memory models.
module tb_fetch_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start3 = 1'b0;
    logic [11:0] imem_addr, imem_addr3, pc, pc3;
    logic        imem_en, imem_en3, instr_valid, instr_valid3, misalign, misalign3;
    logic [31:0] imem_data, imem_data3, instr, instr3, retired, retired3;
    logic        instr_ready = 1'b0, ready3 = 1'b1, isBranch = 1'b0;
    logic [25:0] pcLabel = '0;
    logic [31:0] rd1;
    logic [31:0] rd3 [3];
    int total = 0, bad = 0, n;

    typedef struct {
        int          hold;
        logic        br;
        logic [25:0] lbl;
        logic [11:0] pc;
        logic [31:0] ins;
        logic [11:0] nxt;
        logic        mis;
    } vec_t;
    vec_t v [8];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [11:0] a);
        return a == 12'h010 ? 32'hDEADBEEF : {20'd0, a};
    endfunction

    // reads not enabled return a marker so a wrong capture cycle is visible
    always @(posedge clk) begin
        rd1 <= imem_en ? word(imem_addr) : 32'hBADBAD00;
        rd3[0] <= imem_en3 ? word(imem_addr3) : 32'hBADBAD00;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign imem_data = rd1;
    assign imem_data3 = rd3[2];

    fetch_pc_unit #(.MEM_LATENCY(1), .RESET_PC(12'h000), .PC_STEP(12'd4)) dut (
        .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .isBranch(isBranch), .pcLabel(pcLabel),
        .misalign(misalign), .retired(retired));

    fetch_pc_unit #(.MEM_LATENCY(3), .RESET_PC(12'h010), .PC_STEP(12'd4)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .imem_addr(imem_addr3), .imem_en(imem_en3),
        .imem_data(imem_data3), .instr(instr3), .instr_valid(instr_valid3),
        .instr_ready(ready3), .pc(pc3), .isBranch(1'b0), .pcLabel(26'd0),
        .misalign(misalign3), .retired(retired3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        v[0] = '{0, 1'b0, 26'h0000000, 12'h000, 32'h00000000, 12'h004, 1'b0};
        v[1] = '{0, 1'b0, 26'h0000000, 12'h004, 32'h00000004, 12'h008, 1'b0};
        v[2] = '{0, 1'b1, 26'h0000100, 12'h008, 32'h00000008, 12'h100, 1'b0};
        v[3] = '{0, 1'b1, 26'h3FFFFFE, 12'h100, 32'h00000100, 12'hFFC, 1'b1};
        v[4] = '{0, 1'b0, 26'h0000000, 12'hFFC, 32'h00000FFC, 12'h000, 1'b1};
        v[5] = '{0, 1'b1, 26'h0000010, 12'h000, 32'h00000000, 12'h010, 1'b1};
        v[6] = '{5, 1'b0, 26'h0000000, 12'h010, 32'hDEADBEEF, 12'h014, 1'b1};
        v[7] = '{0, 1'b0, 26'h0000000, 12'h014, 32'h00000014, 12'h018, 1'b1};

        @(negedge clk);
        chk("rst_pc", pc, 12'h000);
        chk("rst_pc3", pc3, 12'h010);
        chk("rst_instr", instr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_en", imem_en, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_ret", retired, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", instr_valid, 0);
            chk("idle_en", imem_en, 0);
        end

        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("lat_en", imem_en3, (k == 0 || k == 5) ? 1 : 0);
            chk("lat_valid", instr_valid3, (k == 4 || k == 9) ? 1 : 0);
            if (k == 0) chk("lat_addr0", imem_addr3, 12'h010);
            if (k == 3) chk("lat_early", instr3, 0);
            if (k == 4) chk("lat_instr0", instr3, 32'hDEADBEEF);
            if (k == 5) chk("lat_addr1", imem_addr3, 12'h014);
            if (k == 9) chk("lat_instr1", instr3, 32'h00000014);
            if (k == 9) chk("lat_ret", retired3, 1);
            @(negedge clk);
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_en", imem_en, 1);
        chk("start_addr", imem_addr, 12'h000);
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!instr_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("valid_wait", instr_valid, 1);
            chk("gap", n, 2);
            chk("pc", pc, v[i].pc);
            chk("instr", instr, v[i].ins);
            chk("hold_en", imem_en, 0);
            for (int k = 0; k < v[i].hold; k++) begin
                instr_ready = 1'b0;
                isBranch = k[0];
                pcLabel = 26'h0000200;
                @(negedge clk);
                chk("bp_pc", pc, v[i].pc);
                chk("bp_instr", instr, v[i].ins);
                chk("bp_valid", instr_valid, 1);
                chk("bp_en", imem_en, 0);
                chk("bp_ret", retired, i);
            end
            instr_ready = 1'b1;
            isBranch = v[i].br;
            pcLabel = v[i].lbl;
            @(negedge clk);
            instr_ready = 1'b0;
            isBranch = 1'b0;
            pcLabel = '0;
            chk("acc_en", imem_en, 1);
            chk("acc_addr", imem_addr, v[i].nxt);
            chk("acc_valid", instr_valid, 0);
            chk("acc_mis", misalign, v[i].mis);
            chk("acc_ret", retired, i + 1);
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_pc", pc, 12'h000);
        chk("mid_instr", instr, 0);
        chk("mid_valid", instr_valid, 0);
        chk("mid_en", imem_en, 0);
        chk("mid_mis", misalign, 0);
        chk("mid_ret", retired, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("post_valid", instr_valid, 0);
            chk("post_instr", instr, 0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("restart_valid", instr_valid, 1);
        chk("restart_pc", pc, 12'h000);
        chk("restart_instr", instr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
